// File: rtl/arith_addf_pipe.sv
// Three-stage pipelined IEEE-754 adder (binary32 or binary64) behind valid/ready handshakes.
// S1 unpacks and aligns the operands, S2 adds the significands, S3 normalizes, rounds and packs.
module arith_addf_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);
  localparam int unsigned EW   = (WIDTH == 64) ? 11 : 8;
  localparam int unsigned MW   = (WIDTH == 64) ? 52 : 23;
  localparam int unsigned SW   = MW + 4;  // hidden + fraction + guard/round/sticky
  localparam int unsigned AW   = MW + 5;  // SW plus carry-out
  localparam int unsigned XW   = EW + 2;
  localparam int unsigned EMAX = (1 << EW) - 1;
  localparam logic [WIDTH-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $fatal(1, "arith_addf_pipe: WIDTH must be 32 or 64");
  end

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic             sx1_q, sx1_d, sy1_q, sy1_d, s2_q, s2_d;
  logic [EW-1:0]    ex1_q, ex1_d, ex2_q, ex2_d;
  logic [SW-1:0]    mx1_q, mx1_d, my1_q, my1_d;
  logic [AW-1:0]    sum2_q, sum2_d;
  logic             sp1_q, sp1_d, sp2_q, sp2_d;
  logic [WIDTH-1:0] spv1_q, spv1_d, spv2_q, spv2_d, res_q, res_d;
  logic             advance;

  assign advance   = !v3_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign result    = res_q;

  // S1: classify, order by magnitude, align the smaller significand
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
  logic [WIDTH-1:0] x, y;
  logic [EW-1:0]    xe, ye, diff;
  logic [MW:0]      xs, ys;
  logic [SW-1:0]    y_ext, y_mask;

  always_comb begin
    a_nan  = (a[WIDTH-2:MW] == EW'(EMAX)) && (a[MW-1:0] != '0);
    b_nan  = (b[WIDTH-2:MW] == EW'(EMAX)) && (b[MW-1:0] != '0);
    a_inf  = (a[WIDTH-2:MW] == EW'(EMAX)) && (a[MW-1:0] == '0);
    b_inf  = (b[WIDTH-2:MW] == EW'(EMAX)) && (b[MW-1:0] == '0);
    a_zero = (a[WIDTH-2:0] == '0);
    b_zero = (b[WIDTH-2:0] == '0);
    swap   = b[WIDTH-2:0] > a[WIDTH-2:0];
    x      = swap ? b : a;
    y      = swap ? a : b;
    xe     = (x[WIDTH-2:MW] == '0) ? EW'(1) : x[WIDTH-2:MW];
    ye     = (y[WIDTH-2:MW] == '0) ? EW'(1) : y[WIDTH-2:MW];
    xs     = {x[WIDTH-2:MW] != '0, x[MW-1:0]};
    ys     = {y[WIDTH-2:MW] != '0, y[MW-1:0]};
    diff   = xe - ye;
    y_ext  = {ys, 3'b000};
    y_mask = ~({SW{1'b1}} << diff);

    v1_d   = v1_q;
    sx1_d  = sx1_q;
    sy1_d  = sy1_q;
    ex1_d  = ex1_q;
    mx1_d  = mx1_q;
    my1_d  = my1_q;
    sp1_d  = sp1_q;
    spv1_d = spv1_q;
    if (advance) begin
      v1_d  = in_valid;
      sx1_d = x[WIDTH-1];
      sy1_d = y[WIDTH-1];
      ex1_d = xe;
      mx1_d = {xs, 3'b000};
      if (32'(diff) >= SW) my1_d = {{(SW-1){1'b0}}, |ys};
      else                 my1_d = (y_ext >> diff) | SW'(|(y_ext & y_mask));
      sp1_d  = 1'b1;
      spv1_d = '0;
      if (a_nan || b_nan)                    spv1_d = QNAN;
      else if (a_inf && b_inf && (a[WIDTH-1] != b[WIDTH-1])) spv1_d = QNAN;
      else if (a_inf)                        spv1_d = a;
      else if (b_inf)                        spv1_d = b;
      else if (a_zero && b_zero)             spv1_d = {a[WIDTH-1] & b[WIDTH-1], {(WIDTH-1){1'b0}}};
      else if (b_zero)                       spv1_d = a;
      else if (a_zero)                       spv1_d = b;
      else                                   sp1_d  = 1'b0;
    end
  end

  // S2: significand add, or subtract when signs differ (never negative after the swap)
  always_comb begin
    v2_d   = v2_q;
    s2_d   = s2_q;
    ex2_d  = ex2_q;
    sum2_d = sum2_q;
    sp2_d  = sp2_q;
    spv2_d = spv2_q;
    if (advance) begin
      v2_d   = v1_q;
      s2_d   = sx1_q;
      ex2_d  = ex1_q;
      sp2_d  = sp1_q;
      spv2_d = spv1_q;
      sum2_d = (sx1_q ^ sy1_q) ? ({1'b0, mx1_q} - {1'b0, my1_q})
                               : ({1'b0, mx1_q} + {1'b0, my1_q});
    end
  end

  // S3: normalize (left shift clamped at exponent 1 for gradual underflow), RNE round, pack
  logic [SW-1:0]    m;
  logic [XW-1:0]    e, lz, lim, sh;
  logic [MW+1:0]    mant_r;
  logic [MW-1:0]    frac;
  logic             hid, rnd;
  logic [WIDTH-1:0] packed_res;

  always_comb begin
    lz = XW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (sum2_q[i]) lz = XW'(SW - 1 - i);
    end
    lim = XW'(ex2_q) - XW'(1);
    sh  = (lz < lim) ? lz : lim;
    if (sum2_q[AW-1]) begin
      m = {sum2_q[AW-1:2], |sum2_q[1:0]};
      e = XW'(ex2_q) + XW'(1);
    end else begin
      m = sum2_q[SW-1:0] << sh;
      e = XW'(ex2_q) - sh;
    end
    rnd    = m[2] & (m[1] | m[0] | m[3]);
    mant_r = (MW+2)'(m[SW-1:3]) + (MW+2)'(rnd);
    if (mant_r[MW+1]) begin
      e    = e + XW'(1);
      frac = mant_r[MW:1];
      hid  = 1'b1;
    end else begin
      frac = mant_r[MW-1:0];
      hid  = mant_r[MW];
    end
    packed_res = {s2_q, hid ? e[EW-1:0] : EW'(0), frac};
    if (e >= XW'(EMAX)) packed_res = {s2_q, EW'(EMAX), {MW{1'b0}}};
    if (sum2_q == '0)   packed_res = '0;
    if (sp2_q)          packed_res = spv2_q;

    v3_d  = advance ? v2_q : v3_q;
    res_d = (advance && v2_q) ? packed_res : res_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      res_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      res_q <= res_d;
    end
    sx1_q  <= sx1_d;
    sy1_q  <= sy1_d;
    ex1_q  <= ex1_d;
    mx1_q  <= mx1_d;
    my1_q  <= my1_d;
    sp1_q  <= sp1_d;
    spv1_q <= spv1_d;
    s2_q   <= s2_d;
    ex2_q  <= ex2_d;
    sum2_q <= sum2_d;
    sp2_q  <= sp2_d;
    spv2_q <= spv2_d;
  end
endmodule

// File: tb/tb_arith_addf_pipe.sv
// Directed bench for arith_addf_pipe (binary32 and binary64 instances) with an in-order
// expected-result queue per instance and a real-arithmetic reference for random binary64 adds.
module tb_arith_addf_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv32, ir32, ov32, or32;
  logic [31:0] a32, b32, r32;
  logic        iv64, ir64, ov64, or64;
  logic [63:0] a64, b64, r64;

  arith_addf_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(or32), .result(r32));
  arith_addf_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .out_valid(ov64), .out_ready(or64), .result(r64));

  localparam logic [63:0] QNAN64 = 64'h7FF8000000000000;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] q32[$];
  logic [63:0] q64[$];
  logic [31:0] pend32;
  logic [63:0] pend64;
  bit          rnd_or64 = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Sample handshakes mid-cycle, then advance one clock edge.
  task automatic tick(output bit acc32, output bit acc64);
    #4;
    acc32 = iv32 && ir32;
    acc64 = iv64 && ir64;
    if (ov32 && or32) begin
      if (q32.size() == 0) check("spurious_out32", 64'(ov32), 64'd0);
      else                 check("result32", 64'(r32), q32.pop_front());
    end
    if (ov64 && or64) begin
      if (q64.size() == 0) check("spurious_out64", 64'(ov64), 64'd0);
      else                 check("result64", r64, q64.pop_front());
    end
    if (acc32) q32.push_back(64'(pend32));
    if (acc64) q64.push_back(pend64);
    @(posedge clk);
    #1;
    if (rnd_or64) or64 = ($urandom_range(0, 3) != 0);
  endtask

  task automatic step();
    bit x0, x1;
    tick(x0, x1);
  endtask

  task automatic send32(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] ex);
    bit acc, d;
    int n = 0;
    a32 = av; b32 = bv; pend32 = ex; iv32 = 1'b1;
    do begin tick(acc, d); n++; end while (!acc && n < 50);
    iv32 = 1'b0;
    if (!acc) check("accept32_timeout", 64'(acc), 64'd1);
  endtask

  task automatic send64(input logic [63:0] av, input logic [63:0] bv, input logic [63:0] ex);
    bit acc, d;
    int n = 0;
    a64 = av; b64 = bv; pend64 = ex; iv64 = 1'b1;
    do begin tick(d, acc); n++; end while (!acc && n < 50);
    iv64 = 1'b0;
    if (!acc) check("accept64_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q64.size() != 0 || ov32 || ov64) && n < 100) begin
      step();
      n++;
    end
    check("drain_left", 64'(q32.size() + q64.size()), 64'd0);
  endtask

  function automatic bit is_nan64(input logic [63:0] v);
    return (v[62:52] == 11'h7FF) && (v[51:0] != '0);
  endfunction

  function automatic logic [63:0] model64(input logic [63:0] x, input logic [63:0] y);
    logic [63:0] r;
    if (is_nan64(x) || is_nan64(y)) return QNAN64;
    r = $realtobits($bitstoreal(x) + $bitstoreal(y));
    if (is_nan64(r)) return QNAN64;
    return r;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ra, rb;
    rst = 1'b1; iv32 = 1'b0; iv64 = 1'b0; or32 = 1'b1; or64 = 1'b1;
    a32 = '0; b32 = '0; a64 = '0; b64 = '0; pend32 = '0; pend64 = '0;
    @(posedge clk);
    #1;
    step();
    step();
    check("rst_out_valid32", 64'(ov32), 64'd0);
    check("rst_result32", 64'(r32), 64'd0);
    check("rst_out_valid64", 64'(ov64), 64'd0);
    rst = 1'b0;
    check("rst_in_ready32", 64'(ir32), 64'd1);
    check("rst_in_ready64", 64'(ir64), 64'd1);

    // out_valid rises on the third rising edge counting the accepting edge
    send32(32'h3F800000, 32'h40000000, 32'h40400000);
    check("lat_edge1", 64'(ov32), 64'd0);
    step();
    check("lat_edge2", 64'(ov32), 64'd0);
    step();
    check("lat_edge3", 64'(ov32), 64'd1);
    drain();

    // back-to-back stream: signed zeros, rounding, range, specials
    send32(32'h3F800000, 32'hBF800000, 32'h00000000);
    send32(32'h80000000, 32'h80000000, 32'h80000000);
    send32(32'h3F800000, 32'h33800000, 32'h3F800000);
    send32(32'h3F800001, 32'h33800000, 32'h3F800002);
    send32(32'h3F800000, 32'h34000000, 32'h3F800001);
    send32(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
    send32(32'h00000001, 32'h00000001, 32'h00000002);
    send32(32'h00800000, 32'h80000001, 32'h007FFFFF);
    send32(32'h7F800000, 32'hFF800000, 32'h7FC00000);
    send32(32'h7FA00000, 32'h3F800000, 32'h7FC00000);
    send32(32'hFF800000, 32'h3F800000, 32'hFF800000);
    send32(32'h3F800000, 32'h80000000, 32'h3F800000);
    send32(32'h80000000, 32'h00000000, 32'h00000000);
    send32(32'h40000000, 32'hBF800000, 32'h3F800000);
    send32(32'h3F800000, 32'h3F800000, 32'h40000000);
    send32(32'hC0400000, 32'h3F800000, 32'hC0000000);
    drain();

    // backpressure: pipe fills, in_ready drops, head result holds
    or32 = 1'b0;
    send32(32'h3F800000, 32'h40000000, 32'h40400000);
    send32(32'h40400000, 32'h3F800000, 32'h40800000);
    send32(32'h40800000, 32'h3F800000, 32'h40A00000);
    check("bp_in_ready", 64'(ir32), 64'd0);
    check("bp_out_valid", 64'(ov32), 64'd1);
    a32 = 32'h40A00000; b32 = 32'h3F800000; pend32 = 32'h40C00000; iv32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_result", 64'(r32), 64'h40400000);
      check("bp_hold_ready", 64'(ir32), 64'd0);
    end
    or32 = 1'b1;
    send32(32'h40A00000, 32'h3F800000, 32'h40C00000);
    send32(32'h40C00000, 32'h3F800000, 32'h40E00000);
    drain();

    // reset with three operations in flight: none may ever emerge
    or32 = 1'b0;
    send32(32'h3F800000, 32'h3F800000, 32'h40000000);
    send32(32'h40000000, 32'h40000000, 32'h40800000);
    send32(32'h40800000, 32'h40800000, 32'h41000000);
    rst = 1'b1;
    step();
    check("midrst_out_valid", 64'(ov32), 64'd0);
    check("midrst_in_ready", 64'(ir32), 64'd1);
    rst = 1'b0;
    q32.delete();
    or32 = 1'b1;
    for (int i = 0; i < 8; i++) step();

    // binary64 directed
    send64(64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000);
    send64(64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 64'h7FF0000000000000);
    send64(64'h3FF0000000000000, 64'hBFF0000000000000, 64'h0000000000000000);
    send64(64'h7FF0000000000000, 64'hFFF0000000000000, QNAN64);
    send64(64'h0000000000000001, 64'h0000000000000001, 64'h0000000000000002);
    send64(64'h3FF0000000000000, 64'h3CA0000000000000, 64'h3FF0000000000000);
    drain();

    // binary64 random against real arithmetic, random output stalls
    rnd_or64 = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 4 == 1) rb[62:52] = ra[62:52] + 11'($urandom_range(0, 60)) - 11'd30;
      if (i % 4 == 2) begin
        ra[62:52] = 11'($urandom_range(0, 3));
        rb[62:52] = 11'($urandom_range(0, 3));
      end
      send64(ra, rb, model64(ra, rb));
    end
    rnd_or64 = 1'b0;
    or64 = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
